// File: rtl/score_bcd_convert_pkg.sv
// Shared constants, FSM encoding and helpers for the score/combo binary-to-BCD converter.
package score_bcd_convert_pkg;

    localparam int unsigned DIGITS_DEFAULT = 8;
    localparam int unsigned BIN_W_DEFAULT  = 27;
    localparam logic [26:0] SAT_VALUE      = 27'd99_999_999;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Largest value representable in 'digits' decimal digits (10^digits - 1).
    function automatic longint unsigned bcd_max(input int unsigned digits);
        longint unsigned v;
        v = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

endpackage

// File: rtl/score_bcd_convert_if.sv
// Request/result bundle between the game logic and the BCD converter.
interface score_bcd_convert_if #(
    parameter int unsigned BIN_W  = 27,
    parameter int unsigned DIGITS = 8
);
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (
        output start, bin,
        input  busy, done, bcd, overflow
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, overflow
    );
endinterface

// File: rtl/score_bcd_convert_bcd_digit_adj.sv
// Double-dabble digit cell: add 3 to a BCD digit that is 5 or more, carry out discarded.
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout_c
);
    assign dout_c = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

// File: rtl/score_bcd_convert.sv
// Sequential binary-to-BCD converter (shift-add-3) feeding the seven-segment display driver.
// Values above 10^DIGITS-1 saturate to all nines and raise overflow.
module score_bcd_convert
    import score_bcd_convert_pkg::*;
#(
    parameter int unsigned BIN_W  = BIN_W_DEFAULT,
    parameter int unsigned DIGITS = DIGITS_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    score_bcd_convert_if.slave conv
);

    localparam int unsigned     BCD_W   = 4 * DIGITS;
    localparam int unsigned     CNT_W   = $clog2(BIN_W + 1);
    localparam longint unsigned MAX_VAL = bcd_max(DIGITS);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   scr_q, scr_d;
    logic [BCD_W-1:0]   scr_adj_c;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               in_range_c;
    logic               unused_msb_c;

    assign in_range_c = (64'(conv.bin) <= MAX_VAL);

    // Saturated input keeps the top digit below 8, so its adjusted MSB never shifts out.
    assign unused_msb_c = scr_adj_c[BCD_W-1];

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din    (scr_q[4*g +: 4]),
            .dout_c (scr_adj_c[4*g +: 4])
        );
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bin_d      = bin_q;
        scr_d      = scr_q;
        bcd_d      = bcd_q;
        ovf_pend_d = ovf_pend_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (conv.start) begin
                    bin_d      = in_range_c ? conv.bin : BIN_W'(MAX_VAL);
                    ovf_pend_d = ~in_range_c;
                    scr_d      = '0;
                    cnt_d      = CNT_W'(BIN_W);
                    busy_d     = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                {scr_d, bin_d} = {scr_adj_c[BCD_W-2:0], bin_q, 1'b0};
                cnt_d          = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = scr_d;
                    ovf_d   = ovf_pend_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bin_q      <= '0;
            scr_q      <= '0;
            bcd_q      <= '0;
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            scr_q      <= scr_d;
            bcd_q      <= bcd_d;
            ovf_pend_q <= ovf_pend_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign conv.busy     = busy_q;
    assign conv.done     = done_q;
    assign conv.bcd      = bcd_q;
    assign conv.overflow = ovf_q;

endmodule

// File: tb/tb_score_bcd_convert.sv
// Self-checking bench for score_bcd_convert: vector table, directed corner sequences, random vs. decimal model.
module tb_score_bcd_convert;

    localparam int unsigned LAT = 27;

    typedef struct {
        logic [26:0] bin;
        logic [31:0] exp_bcd;
        logic        exp_ovf;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    score_bcd_convert_if conv_if ();

    score_bcd_convert dut (
        .clk   (clk),
        .reset (reset),
        .conv  (conv_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decimal reference: saturate, then peel off base-10 digits.
    function automatic logic [31:0] model_bcd(input int unsigned v);
        int unsigned x;
        logic [31:0] r;
        x = (v > 32'd99_999_999) ? 32'd99_999_999 : v;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Caller has already driven start for the sampling edge; returns edges until done.
    task automatic wait_done(output int lat, output int busy_bad, output int hold_bad);
        logic [31:0] held;
        lat      = -1;
        busy_bad = 0;
        hold_bad = 0;
        held     = conv_if.bcd;
        @(posedge clk);
        @(negedge clk);
        conv_if.start = 1'b0;
        conv_if.bin   = 27'($urandom);
        if (conv_if.busy !== 1'b1) busy_bad++;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (conv_if.done === 1'b1) begin
                lat = k;
                if (conv_if.busy !== 1'b0) busy_bad++;
                break;
            end
            if (conv_if.busy !== 1'b1) busy_bad++;
            if (conv_if.bcd !== held) hold_bad++;
        end
    endtask

    task automatic do_check(input string name, input logic [26:0] b,
                            input logic [31:0] exp_bcd, input logic exp_ovf);
        int lat, busy_bad, hold_bad;
        conv_if.start = 1'b1;
        conv_if.bin   = b;
        wait_done(lat, busy_bad, hold_bad);
        check({name, "_latency"}, 64'(lat), 64'(LAT));
        check({name, "_busy"}, 64'(busy_bad), 64'd0);
        check({name, "_hold"}, 64'(hold_bad), 64'd0);
        check({name, "_bcd"}, 64'(conv_if.bcd), 64'(exp_bcd));
        check({name, "_ovf"}, 64'(conv_if.overflow), 64'(exp_ovf));
    endtask

    initial begin
        vec_t        vecs[$];
        int          ndone, done_at, lat, busy_bad, hold_bad;
        logic [26:0] rb;

        n_checks = 0;
        n_fail   = 0;
        reset         = 1'b1;
        conv_if.start = 1'b0;
        conv_if.bin   = '0;

        vecs.push_back('{27'd0,            32'h0000_0000, 1'b0});
        vecs.push_back('{27'd12_345_678,   32'h1234_5678, 1'b0});
        vecs.push_back('{27'd99_999_999,   32'h9999_9999, 1'b0});
        vecs.push_back('{27'h7FF_FFFF,     32'h9999_9999, 1'b1});
        vecs.push_back('{27'd5,            32'h0000_0005, 1'b0});
        vecs.push_back('{27'd100_000_000,  32'h9999_9999, 1'b1});
        vecs.push_back('{27'd10_000_000,   32'h1000_0000, 1'b0});
        vecs.push_back('{27'd80_808_080,   32'h8080_8080, 1'b0});

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(conv_if.busy), 64'd0);
        check("reset_done", 64'(conv_if.done), 64'd0);
        check("reset_bcd", 64'(conv_if.bcd), 64'd0);
        check("reset_ovf", 64'(conv_if.overflow), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_check($sformatf("vec%0d", i), vecs[i].bin, vecs[i].exp_bcd, vecs[i].exp_ovf);
        end

        // Start pulses and bin changes while busy must be ignored.
        conv_if.start = 1'b1;
        conv_if.bin   = 27'd42;
        @(posedge clk);
        ndone   = 0;
        done_at = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            conv_if.start = (k == 9) ? 1'b1 : 1'b0;
            conv_if.bin   = (k == 9) ? 27'd777 : 27'($urandom);
            @(posedge clk);
            #1;
            if (conv_if.done === 1'b1) begin
                ndone++;
                done_at = k;
            end
        end
        @(negedge clk);
        conv_if.start = 1'b0;
        check("ignore_done_count", 64'(ndone), 64'd1);
        check("ignore_done_at", 64'(done_at), 64'(LAT));
        check("ignore_bcd", 64'(conv_if.bcd), 64'h0000_0042);
        check("ignore_ovf", 64'(conv_if.overflow), 64'd0);

        // Reset mid-conversion aborts with no done pulse.
        conv_if.start = 1'b1;
        conv_if.bin   = 27'd1000;
        @(posedge clk);
        @(negedge clk);
        conv_if.start = 1'b0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy", 64'(conv_if.busy), 64'd0);
        check("abort_done", 64'(conv_if.done), 64'd0);
        check("abort_bcd", 64'(conv_if.bcd), 64'd0);
        check("abort_ovf", 64'(conv_if.overflow), 64'd0);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (conv_if.done === 1'b1) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        do_check("after_abort", 27'd1000, 32'h0000_1000, 1'b0);

        // Back-to-back: new start issued in the done cycle.
        do_check("b2b_first", 27'd9, 32'h0000_0009, 1'b0);
        conv_if.start = 1'b1;
        conv_if.bin   = 27'd10;
        wait_done(lat, busy_bad, hold_bad);
        check("b2b_latency", 64'(lat), 64'(LAT));
        check("b2b_hold_first", 64'(hold_bad), 64'd0);
        check("b2b_busy", 64'(busy_bad), 64'd0);
        check("b2b_bcd", 64'(conv_if.bcd), 64'h0000_0010);

        // Random values, mixing in-range and full-width inputs.
        for (int i = 0; i < 40; i++) begin
            rb = (i % 3 == 0) ? 27'($urandom) : 27'($urandom_range(99_999_999));
            do_check($sformatf("rand%0d", i), rb, model_bcd(32'(rb)),
                     (32'(rb) > 32'd99_999_999) ? 1'b1 : 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
